// File: rtl/mem_resp_stage_pkg.sv
// Shared definitions for the MEM response stage: load-control bit indices,
// stage state encoding and bypass bundle width.
package mem_resp_stage_pkg;

    // Bit positions inside the one-hot {ld_w, ld_b, ld_bu, ld_h, ld_hu} vector
    localparam int LD_W  = 4;
    localparam int LD_B  = 3;
    localparam int LD_BU = 2;
    localparam int LD_H  = 1;
    localparam int LD_HU = 0;
    localparam int LD_CTRL_W = 5;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_DONE  = 2'd2
    } ms_state_t;

    // {byp_we, byp_wait, byp_waddr, byp_data} as seen by the ID hazard unit
    localparam int MEM_BYPASS_LEN = 1 + 1 + 5 + 32;

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

endpackage

// File: rtl/mem_resp_stage_ld_align.sv
// Combinational load aligner: picks the addressed byte/half of a bus word
// and sign- or zero-extends it to 32 bits.
module ld_align
    import mem_resp_stage_pkg::*;
(
    input  logic [31:0]          rdata,
    input  logic [1:0]           addr_lo,
    input  logic [LD_CTRL_W-1:0] ld_ctrl,
    output logic [31:0]          value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        value    = '0;
        if (ld_ctrl[LD_W])       value = rdata;
        else if (ld_ctrl[LD_B])  value = ext8(byte_sel, 1'b1);
        else if (ld_ctrl[LD_BU]) value = ext8(byte_sel, 1'b0);
        else if (ld_ctrl[LD_H])  value = ext16(half_sel, 1'b1);
        else if (ld_ctrl[LD_HU]) value = ext16(half_sel, 1'b0);
    end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM stage: waits for the in-order data-bus response, aligns load data and
// holds the result for WB; responses of flushed ops are counted and dropped.
// Define MEM_LD_FWD_EN to forward aligned load data on the data_ok cycle.
module mem_resp_stage
    import mem_resp_stage_pkg::*;
#(
    parameter int PAY_W      = 123,
    parameter int CANCEL_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_is_mem,
    input  logic [LD_CTRL_W-1:0] in_ld_ctrl,
    input  logic [31:0]          in_alu_result,
    input  logic [PAY_W-1:0]     in_pay,
    input  logic                 in_rf_we,
    input  logic [4:0]           in_rf_waddr,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [PAY_W-1:0]     out_pay,
    output logic                 byp_we,
    output logic [4:0]           byp_waddr,
    output logic                 byp_wait,
    output logic [31:0]          byp_data
);

    localparam int CNT_W = $clog2(CANCEL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CANCEL_MAX);

    ms_state_t            state, state_nxt;
    logic [CNT_W-1:0]     cancel_cnt;
    logic [31:0]          result_p1;
    logic [PAY_W-1:0]     pay_p1;
    logic [LD_CTRL_W-1:0] ld_ctrl_p1;
    logic [1:0]           addr_lo_p1;
    logic                 rf_we_p1;
    logic [4:0]           rf_waddr_p1;

    logic        accept, own_ok, cnt_zero, cnt_inc, cnt_dec, is_load_p1;
    logic [31:0] ld_value;

    assign cnt_zero   = (cancel_cnt == '0);
    assign is_load_p1 = |ld_ctrl_p1;
    assign in_ready   = ((state == MS_EMPTY) || ((state == MS_DONE) && out_ready))
                        && (cancel_cnt != CNT_FULL) && !flush;
    assign accept     = in_valid && in_ready;
    assign own_ok     = data_sram_data_ok && cnt_zero && (state == MS_WAIT) && !flush;
    assign cnt_dec    = data_sram_data_ok && !cnt_zero;
    // A flush in WAIT orphans our outstanding request unless its response is arriving now
    assign cnt_inc    = flush && (state == MS_WAIT) && !(data_sram_data_ok && cnt_zero);

    ld_align u_ld_align (
        .rdata   (data_sram_rdata),
        .addr_lo (addr_lo_p1),
        .ld_ctrl (ld_ctrl_p1),
        .value   (ld_value)
    );

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = MS_EMPTY;
        end else begin
            case (state)
                MS_EMPTY: if (accept) state_nxt = in_is_mem ? MS_WAIT : MS_DONE;
                MS_WAIT:  if (own_ok) state_nxt = MS_DONE;
                MS_DONE: begin
                    if (accept)         state_nxt = in_is_mem ? MS_WAIT : MS_DONE;
                    else if (out_ready) state_nxt = MS_EMPTY;
                end
                default:  state_nxt = MS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MS_EMPTY;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   cancel_cnt <= cancel_cnt + CNT_W'(1);
                2'b01:   cancel_cnt <= cancel_cnt - CNT_W'(1);
                default: cancel_cnt <= cancel_cnt;
            endcase
        end
    end

    // Stage register: captured on accept, load data overwrites the result on own data_ok
    always_ff @(posedge clk) begin
        if (reset) begin
            result_p1   <= '0;
            pay_p1      <= '0;
            ld_ctrl_p1  <= '0;
            addr_lo_p1  <= '0;
            rf_we_p1    <= 1'b0;
            rf_waddr_p1 <= '0;
        end else if (accept) begin
            result_p1   <= in_alu_result;
            pay_p1      <= in_pay;
            ld_ctrl_p1  <= in_ld_ctrl;
            addr_lo_p1  <= in_alu_result[1:0];
            rf_we_p1    <= in_rf_we;
            rf_waddr_p1 <= in_rf_waddr;
        end else if (own_ok && is_load_p1) begin
            result_p1   <= ld_value;
        end
    end

    assign out_valid  = (state == MS_DONE);
    assign out_result = result_p1;
    assign out_pay    = pay_p1;
    assign byp_we     = rf_we_p1 && (state != MS_EMPTY);
    assign byp_waddr  = rf_waddr_p1;

`ifdef MEM_LD_FWD_EN
    assign byp_wait = (state == MS_WAIT) && is_load_p1 && !own_ok;
    assign byp_data = (own_ok && is_load_p1) ? ld_value : result_p1;
`else
    assign byp_wait = (state == MS_WAIT) && is_load_p1;
    assign byp_data = result_p1;
`endif

    // A response with nothing outstanding means the bus and the stage disagree
    a_no_orphan_ok: assert property (@(posedge clk) disable iff (reset)
        data_sram_data_ok |-> ((state == MS_WAIT) || !cnt_zero));

endmodule
